branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Parametrised direct-mapped branch target buffer with per-entry saturating direction counters for the pipelined RV32I core. It replaces the current stall-on-every-branch policy in IF. IF looks up the fetch PC combinationally and gets a predicted next PC. EX writes back each resolved branch or jump one update per cycle, and a multi-cycle flush sequencer invalidates the whole table, for example on fence.i.

Parameters:
DATA_LEN, 32, PC and target width
INDEX_BITS, 4, log2 of entry count (16 entries)
TAG_BITS, 8, stored tag width; INDEX_BITS+TAG_BITS+2 <= DATA_LEN
CTR_BITS, 2, direction counter width (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (0 = reset)
lookup_en  input  1  IF lookup valid
lookup_pc  input  DATA_LEN  fetch PC
pred_hit  output  1  valid entry with matching tag
pred_taken  output  1  predict taken
pred_target  output  DATA_LEN  predicted next PC
update_en  input  1  EX resolved a branch/jump this cycle
update_pc  input  DATA_LEN  PC of the resolved instruction
update_taken  input  1  actual outcome
update_uncond  input  1  resolved instruction is JAL/JALR
update_target  input  DATA_LEN  actual target
flush_req  input  1  request full invalidation (pulse)
busy  output  1  flush in progress

Behaviour:
- Index = pc[INDEX_BITS+1:2]; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]. pc[1:0] ignored.
- Entry contents: valid, tag, target[DATA_LEN-1:0], ctr[CTR_BITS-1:0].
- Lookup (combinational, zero latency):
  - pred_hit = lookup_en & !busy & valid & tag match.
  - pred_taken = pred_hit & ctr MSB.
  - pred_target = stored target when pred_taken, else lookup_pc+4 (mod 2^DATA_LEN).
  - lookup_en=0 gives hit=0, taken=0, target=lookup_pc+4.
- Update (registered, visible from the next cycle; no write-to-read bypass; same-cycle lookup of the same index sees old contents). Applies only when update_en & state IDLE:
  - Hit, update_uncond: ctr=all-ones, target=update_target.
  - Hit, taken: ctr saturating +1, target=update_target.
  - Hit, not taken: ctr saturating -1 (floor 0); target unchanged.
  - Miss, taken: allocate/replace; valid=1, tag, target written. ctr=all-ones if uncond, else weakly-taken 2^(CTR_BITS-1).
  - Miss, not taken: no change.
- FSM with two states:
  - IDLE: busy=0. flush_req moves to FLUSH at the next edge and sets ptr=0.
  - FLUSH: busy=1. Each cycle clears valid[ptr] and increments ptr. In the cycle ptr = 2^INDEX_BITS-1 it clears the last entry and returns to IDLE.
  - busy is high for exactly 2^INDEX_BITS cycles.
  - flush_req and update_en are ignored during FLUSH; dropped updates are not queued.
  - flush_req and update_en in the same IDLE cycle: the update is written, then the flush erases it.
- Counters and targets are not cleared by a flush; only valid is.
- Reset (asynchronous, active-low):
  - All valid=0, all ctr=2^(CTR_BITS-1)-1 (weakly not taken), targets and tags=0.
  - FSM=IDLE, ptr=0, busy=0.
  - Outputs are therefore hit=0, taken=0, target=lookup_pc+4.
  - Reset asserted mid-flush aborts the flush immediately.
- Synchronous logic is inactive while reset=0.

Test Plan:
1. Release reset; lookup_en=1, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, busy=0.
2. Update pc=0x100, taken=1, uncond=0, target=0x80 -> next cycle lookup 0x100: hit=1, taken=1, target=0x80 (ctr=2). A same-cycle lookup during the update still misses.
3. Hysteresis on 0x100:
   - not-taken -> ctr=1, taken=0, target=0x104; not-taken -> ctr=0.
   - taken -> ctr=1, still not taken; taken -> ctr=2, taken; taken twice -> saturates at 3.
   - Then one not-taken -> ctr=2, still taken.
4. Aliasing: entry 0x100 valid; lookup 0x140 (same index 0, different tag) -> miss. Update 0x140 taken, target 0x200 -> 0x140 hits with target 0x200 and 0x100 now misses. Not-taken update to miss pc 0x180 -> no allocation.
5. Flush: entries at 0x100, 0x104, 0x108 valid; pulse flush_req -> busy=1 for exactly 16 cycles, lookups miss throughout. An update to 0x10C during busy is dropped; after busy falls, all four PCs miss.
6. Assert reset at flush cycle 5 -> busy=0 asynchronously, all entries invalid. After release, an update of 0x100 with uncond=1 -> ctr=3, taken.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational, updates are registered, and a sequencer invalidates one entry per cycle.
module branch_predictor #(
  parameter int DATA_LEN   = 32,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8,
  parameter int CTR_BITS   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lookup_en,
  input  logic [DATA_LEN-1:0] lookup_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [DATA_LEN-1:0] pred_target,
  input  logic                update_en,
  input  logic [DATA_LEN-1:0] update_pc,
  input  logic                update_taken,
  input  logic                update_uncond,
  input  logic [DATA_LEN-1:0] update_target,
  input  logic                flush_req,
  output logic                busy,
  output logic                dbg_state
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   ptr_q, ptr_d;

  logic                    valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]     tag_q    [ENTRIES];
  logic [DATA_LEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0]     ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0]   lk_idx, up_idx;
  logic [TAG_BITS-1:0]     lk_tag, up_tag;
  logic                    up_hit, up_we, up_target_we;
  logic [CTR_BITS-1:0]     up_ctr;
  logic                    unused_pc_bits;

  assign lk_idx = lookup_pc[INDEX_BITS+1:2];
  assign lk_tag = lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign up_idx = update_pc[INDEX_BITS+1:2];
  assign up_tag = update_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign unused_pc_bits = ^update_pc;

  assign busy      = (state_q == FLUSH);
  assign dbg_state = state_q;

  // Lookups are masked while flushing so stale entries never steer fetch.
  always_comb begin
    pred_hit    = lookup_en && !busy && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + DATA_LEN'(4);
  end

  always_comb begin
    up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_we        = update_en && (state_q == IDLE) && (up_hit || update_taken);
    up_target_we = !up_hit || update_uncond || update_taken;
    up_ctr       = ctr_q[up_idx];
    if (!up_hit) begin
      up_ctr = update_uncond ? CTR_MAX : CTR_WT;
    end else if (update_uncond) begin
      up_ctr = CTR_MAX;
    end else if (update_taken) begin
      if (ctr_q[up_idx] != CTR_MAX) up_ctr = ctr_q[up_idx] + CTR_BITS'(1);
    end else begin
      if (ctr_q[up_idx] != '0) up_ctr = ctr_q[up_idx] - CTR_BITS'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          ptr_d   = '0;
        end
      end
      FLUSH: begin
        ptr_d = ptr_q + INDEX_BITS'(1);
        if (&ptr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (up_we) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        ctr_q[up_idx]   <= up_ctr;
        if (up_target_we) target_q[up_idx] <= update_target;
      end
      // Only valid bits are cleared; counters and targets survive a flush.
      if (state_q == FLUSH) valid_q[ptr_q] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, counter hysteresis, aliasing, flush and reset abort.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_uncond;
  logic [31:0] update_target;
  logic        flush_req;
  logic        busy;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;

  branch_predictor dut (
    .clk           (clk),
    .reset         (reset),
    .lookup_en     (lookup_en),
    .lookup_pc     (lookup_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_uncond (update_uncond),
    .update_target (update_target),
    .flush_req     (flush_req),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic h, input logic tk, input logic [31:0] tg);
    lookup_pc = pc;
    #1;
    check({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, h});
    check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, tk});
    check({tag, ".target"}, pred_target, tg);
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic unc,
                           input logic [31:0] tg);
    update_en     = 1'b1;
    update_pc     = pc;
    update_taken  = tk;
    update_uncond = unc;
    update_target = tg;
    step();
    update_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; lookup_en = 1'b0; lookup_pc = '0;
    update_en = 1'b0; update_pc = '0; update_taken = 1'b0; update_uncond = 1'b0;
    update_target = '0; flush_req = 1'b0;
    step(); step();
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.state", {31'd0, dbg_state}, 32'd0);
    reset = 1'b1;
    step();

    // 1: empty table
    lookup_en = 1'b1;
    look("t1", 32'h100, 1'b0, 1'b0, 32'h104);
    check("t1.busy", {31'd0, busy}, 32'd0);

    // 2: allocate, same-cycle lookup sees old contents
    update_en = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_uncond = 1'b0;
    update_target = 32'h80;
    look("t2.same", 32'h100, 1'b0, 1'b0, 32'h104);
    step();
    update_en = 1'b0;
    look("t2.alloc", 32'h100, 1'b1, 1'b1, 32'h80);

    // 3: hysteresis 2->1->0->1->2->3->3->2->1
    do_update(32'h100, 1'b0, 1'b0, 32'h0);  look("t3.c1", 32'h100, 1'b1, 1'b0, 32'h104);
    do_update(32'h100, 1'b0, 1'b0, 32'h0);  look("t3.c0", 32'h100, 1'b1, 1'b0, 32'h104);
    do_update(32'h100, 1'b1, 1'b0, 32'h80); look("t3.c1b", 32'h100, 1'b1, 1'b0, 32'h104);
    do_update(32'h100, 1'b1, 1'b0, 32'h80); look("t3.c2", 32'h100, 1'b1, 1'b1, 32'h80);
    do_update(32'h100, 1'b1, 1'b0, 32'h80); look("t3.c3", 32'h100, 1'b1, 1'b1, 32'h80);
    do_update(32'h100, 1'b1, 1'b0, 32'h80); look("t3.sat", 32'h100, 1'b1, 1'b1, 32'h80);
    do_update(32'h100, 1'b0, 1'b0, 32'h0);  look("t3.c2b", 32'h100, 1'b1, 1'b1, 32'h80);
    do_update(32'h100, 1'b0, 1'b0, 32'h0);  look("t3.c1c", 32'h100, 1'b1, 1'b0, 32'h104);

    // 4: aliasing on index 0
    look("t4.alias", 32'h140, 1'b0, 1'b0, 32'h144);
    do_update(32'h140, 1'b1, 1'b0, 32'h200);
    look("t4.new", 32'h140, 1'b1, 1'b1, 32'h200);
    look("t4.old", 32'h100, 1'b0, 1'b0, 32'h104);
    do_update(32'h180, 1'b0, 1'b0, 32'h900);
    look("t4.noalloc", 32'h180, 1'b0, 1'b0, 32'h184);
    look("t4.kept", 32'h140, 1'b1, 1'b1, 32'h200);
    lookup_en = 1'b0;
    look("t4.lken0", 32'h140, 1'b0, 1'b0, 32'h144);
    lookup_en = 1'b1;

    // 5: full flush, update during busy is dropped
    do_update(32'h100, 1'b1, 1'b0, 32'h80);
    do_update(32'h104, 1'b1, 1'b0, 32'h300);
    do_update(32'h108, 1'b1, 1'b0, 32'h400);
    look("t5.pre", 32'h104, 1'b1, 1'b1, 32'h300);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        update_en = 1'b1; update_pc = 32'h10C; update_taken = 1'b1;
        update_uncond = 1'b0; update_target = 32'h700;
      end
      check($sformatf("t5.busy%0d", i), {31'd0, busy}, 32'd1);
      look($sformatf("t5.mask%0d", i), 32'h104, 1'b0, 1'b0, 32'h108);
      step();
      update_en = 1'b0;
    end
    check("t5.done", {31'd0, busy}, 32'd0);
    look("t5.a", 32'h100, 1'b0, 1'b0, 32'h104);
    look("t5.b", 32'h104, 1'b0, 1'b0, 32'h108);
    look("t5.c", 32'h108, 1'b0, 1'b0, 32'h10C);
    look("t5.d", 32'h10C, 1'b0, 1'b0, 32'h110);

    // 6: reset aborts flush, then unconditional allocation
    do_update(32'h100, 1'b1, 1'b0, 32'h80);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t6.busy_mid", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("t6.busy_rst", {31'd0, busy}, 32'd0);
    step();
    reset = 1'b1;
    look("t6.inv", 32'h100, 1'b0, 1'b0, 32'h104);
    step();
    check("t6.busy_rel", {31'd0, busy}, 32'd0);
    do_update(32'h100, 1'b1, 1'b1, 32'h500);
    look("t6.jal", 32'h100, 1'b1, 1'b1, 32'h500);
    do_update(32'h100, 1'b0, 1'b0, 32'h0);
    look("t6.c2", 32'h100, 1'b1, 1'b1, 32'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
